// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_pkg
// Brief    : State encoding and line levels shared by the FIFO-fed UART TX.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_uart_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/baud_tick_counter.sv
`default_nettype none
// ============================================================================
// Module   : baud_tick_counter
// Brief    : Bit-period counter; out_tick marks the last clock of each period.
// Revision : 1.0 - initial release
// ============================================================================
module baud_tick_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic in_clock,
   input  logic in_reset,
   input  logic in_clear,
   output logic out_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (in_clear || (cnt_q == LAST_CNT)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out_tick = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Brief    : Pops words from a show-ahead FIFO and sends them as UART frames.
//            Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  in_clock,
   input  logic                  in_reset,
   input  logic                  in_empty,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_take,
   output logic                  out_tx,
   output logic                  out_busy
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  tx_q, tx_d;
   logic                  tick;
   logic                  take;
`ifdef FIFO_UART_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   // Held in clear for the whole of IDLE so START always begins at count 0.
   baud_tick_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .in_clock (in_clock),
      .in_reset (in_reset),
      .in_clear (state_q == IDLE),
      .out_tick (tick)
   );

   assign take = (state_q == IDLE) && !in_empty && !in_reset;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      // tx_d always carries the level for the state being entered.
      case (state_q)
         IDLE: begin
            tx_d      = STOP_BIT;
            bit_cnt_d = '0;
            if (take) begin
               shift_d = in_data;
`ifdef FIFO_UART_TX_PARITY_EN
               parity_d = ^in_data;
`endif
               tx_d    = START_BIT;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               tx_d    = shift_q[0];
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               tx_d      = shift_d[0];
               if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = PARITY;
`else
                  tx_d    = STOP_BIT;
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               tx_d    = STOP_BIT;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               tx_d    = STOP_BIT;
               state_d = IDLE;
            end
         end
         default: begin
            tx_d    = STOP_BIT;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= STOP_BIT;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign out_take = take;
   assign out_tx   = tx_q;
   assign out_busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_uart_tx
// Brief    : Scoreboard bench for fifo_uart_tx (DATA_WIDTH=8, CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   typedef struct packed {
      logic [7:0] word;
      logic       par;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_empty = 1'b0;
   logic [7:0] in_data = 8'h3C;
   logic       out_take;
   logic       out_tx;
   logic       out_busy;

   exp_t  sb_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;
   time   take_time;

   fifo_uart_tx #(
      .DATA_WIDTH   (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .in_clock (clk),
      .in_reset (rst),
      .in_empty (in_empty),
      .in_data  (in_data),
      .out_take (out_take),
      .out_tx   (out_tx),
      .out_busy (out_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [7:0] w, input logic p);
      exp_t e;
      e.word = w;
      e.par  = p;
      sb_q.push_back(e);
   endtask

   // Returns 1ns after the edge that consumes the pop.
   task automatic wait_take(input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (out_take) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_take_seen"}, 32'(seen), 1);
      @(posedge clk);
      take_time = $time;
      #1;
   endtask

   task automatic send_one(input logic [7:0] w, input logic p, input string name);
      int busy_cnt = 0;
      push(w, p);
      in_data  = w;
      in_empty = 1'b0;
      wait_take(name);
      in_empty = 1'b1;
      in_data  = ~w;
      for (int n = 0; n < FRAME + 10; n++) begin
         @(negedge clk);
         if (out_busy) busy_cnt++;
      end
      check({name, "_busy_len"}, busy_cnt, FRAME);
   endtask

   // Monitor: decodes every frame that follows a take against the scoreboard.
   initial begin : monitor
      exp_t        e;
      logic [10:0] lvl;
      logic [3:0]  txv;
      logic [3:0]  stv;
      bit          just_ended;
      bit          aborted;
      just_ended = 1'b0;
      forever begin
         @(negedge clk);
         if (just_ended) begin
            check("idle_gap_busy_tx", {out_busy, out_tx}, 2'b01);
            just_ended = 1'b0;
         end
         if (out_take && !rst) begin
            check("take_has_expect", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               lvl = '0;
               for (int k = 0; k < 8; k++) lvl[k+1] = e.word[k];
`ifdef FIFO_UART_TX_PARITY_EN
               lvl[9] = e.par;
`endif
               lvl[NBITS-1] = 1'b1;
               aborted = 1'b0;
               for (int b = 0; b < NBITS; b++) begin
                  for (int c = 0; c < CPB; c++) begin
                     @(negedge clk);
                     if (rst) begin
                        aborted = 1'b1;
                        break;
                     end
                     txv[c] = out_tx;
                     stv[c] = out_busy & ~out_take;
                  end
                  if (aborted) break;
                  check($sformatf("w%02h_bit%0d_tx", e.word, b), txv, {4{lvl[b]}});
                  check($sformatf("w%02h_bit%0d_busy_notake", e.word, b), stv, 4'hF);
               end
               if (!aborted) just_ended = 1'b1;
            end
         end
      end
   end

   initial begin : stimulus
      int  n_take, n_low, n_busy;
      time t1;
      bit  rst_ok;

      // Reset held with a word waiting: no pop, line idle.
      push(8'h3C, 1'b0);
      rst_ok = 1'b1;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (out_take !== 1'b0 || out_tx !== 1'b1 || out_busy !== 1'b0) rst_ok = 1'b0;
      end
      check("reset_outputs_ok", 32'(rst_ok), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("release_take", 32'(out_take), 1);
      @(posedge clk);
      #1 check("release_first_edge_busy", 32'(out_busy), 1);
      in_empty = 1'b1;
      repeat (FRAME + 3) @(posedge clk);
      #1;

      send_one(8'hA5, 1'b0, "a5");
      send_one(8'h07, 1'b1, "w07");

      // Back-to-back words with the FIFO never empty.
      push(8'h00, 1'b0);
      push(8'hFF, 1'b0);
      in_data  = 8'h00;
      in_empty = 1'b0;
      wait_take("b2b_first");
      t1 = take_time;
      in_data = 8'hFF;
      wait_take("b2b_second");
      in_empty = 1'b1;
      check("b2b_period", 32'((take_time - t1) / 10), FRAME + 1);
      repeat (FRAME + 3) @(posedge clk);
      #1;

      // FIFO empty for 100 clocks.
      n_take = 0; n_low = 0; n_busy = 0;
      in_empty = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (out_take) n_take++;
         if (!out_tx) n_low++;
         if (out_busy) n_busy++;
      end
      check("empty_take_cnt", n_take, 0);
      check("empty_tx_low_cnt", n_low, 0);
      check("empty_busy_cnt", n_busy, 0);

      // Reset pulse during data bit 3 of 0x5A, next word waiting.
      push(8'h5A, 1'b0);
      in_data  = 8'h5A;
      in_empty = 1'b0;
      wait_take("w5a");
      in_data = 8'h81;
      push(8'h81, 1'b0);
      repeat (16) @(posedge clk);
      #1 check("w5a_bit3_before_reset", {out_busy, out_tx}, 2'b11);
      #1 rst = 1'b1;
      #1 check("midframe_reset_async", {out_busy, out_tx, out_take}, 3'b010);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("midframe_release_take", 32'(out_take), 1);
      @(posedge clk);
      #1 check("midframe_release_busy", 32'(out_busy), 1);
      in_empty = 1'b1;
      repeat (FRAME + 5) @(posedge clk);
      #1;

      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
